// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

  // Controller delivers byte +0 in [31:24]; RISC-V wants it in [7:0].
  function automatic logic [31:0] byte_swap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/if_icache.sv
// Direct-mapped one-word-per-line instruction cache (used with IF_ICACHE_EN).
// Addresses are word addresses (byte address [31:2]).
module if_icache #(
  parameter int unsigned LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] lk_word,
  output logic        lk_hit_c,
  output logic [31:0] lk_data_c,
  input  logic        fill_we,
  input  logic [29:0] fill_word,
  input  logic [31:0] fill_data
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  assign lk_idx   = lk_word[IDX_W-1:0];
  assign lk_tag   = lk_word[29:IDX_W];
  assign fill_idx = fill_word[IDX_W-1:0];
  assign fill_tag = fill_word[29:IDX_W];

  // Combinational lookup.
  assign lk_hit_c  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_data_c = data_q[lk_idx];

  // Valid bits: cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: one word fetch in flight at a time, redirect
// handling with drop of in-flight responses, valid/ready hand-off to decode.
// Optional macro IF_ICACHE_EN adds a direct-mapped instruction cache.
module if_fetch
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter int unsigned ICACHE_LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ok,
  input  logic [31:0] mem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        mem_req_d;
  logic [31:0] mem_addr_d;
  logic        id_valid_d;
  logic [31:0] id_inst_d;
  logic [31:0] id_pc_d;

  logic [31:0] rpc_c;
  logic        fetch_go_c;
  logic [31:0] fetch_addr_c;

  assign rpc_c = redirect_pc & 32'hFFFF_FFFC;

`ifdef IF_ICACHE_EN
  logic        hit_c;
  logic [31:0] hit_data_c;
  logic        fill_we_c;

  assign fill_we_c = (state_q == WAIT) && mem_ok && !redirect;

  if_icache #(.LINES(ICACHE_LINES)) u_icache (
    .clk       (clk),
    .rst       (rst),
    .lk_word   (fetch_addr_c[31:2]),
    .lk_hit_c  (hit_c),
    .lk_data_c (hit_data_c),
    .fill_we   (fill_we_c),
    .fill_word (pc_q[31:2]),
    .fill_data (byte_swap(mem_data))
  );
`endif

  // Decide whether a new fetch starts this cycle and at which address.
  always_comb begin
    fetch_go_c   = 1'b0;
    fetch_addr_c = pc_q;
    unique case (state_q)
      IDLE: fetch_go_c = 1'b1;
      WAIT: begin
        if (redirect && mem_ok) begin
          fetch_go_c   = 1'b1;
          fetch_addr_c = rpc_c;
        end
      end
      DROP: begin
        if (mem_ok) begin
          fetch_go_c   = 1'b1;
          fetch_addr_c = redirect ? rpc_c : pend_q;
        end
      end
      OUT: begin
        if (redirect) begin
          fetch_go_c   = 1'b1;
          fetch_addr_c = rpc_c;
        end else if (id_ready) begin
          fetch_go_c   = 1'b1;
          fetch_addr_c = pc_q + 32'd4;
        end
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    mem_req_d  = mem_req;
    mem_addr_d = mem_addr;
    id_valid_d = id_valid;
    id_inst_d  = id_inst;
    id_pc_d    = id_pc;

    unique case (state_q)
      WAIT: begin
        if (redirect && !mem_ok) begin
          pend_d  = rpc_c;
          state_d = DROP;
        end else if (mem_ok && !redirect) begin
          id_valid_d = 1'b1;
          id_inst_d  = byte_swap(mem_data);
          id_pc_d    = pc_q;
          mem_req_d  = 1'b0;
          state_d    = OUT;
        end
      end
      DROP: begin
        if (redirect && !mem_ok) begin
          pend_d = rpc_c;
        end
      end
      default: ;
    endcase

    if (fetch_go_c) begin
      state_d    = WAIT;
      pc_d       = fetch_addr_c;
      mem_addr_d = fetch_addr_c;
      mem_req_d  = 1'b1;
      id_valid_d = 1'b0;
`ifdef IF_ICACHE_EN
      if (hit_c) begin
        state_d    = OUT;
        mem_req_d  = 1'b0;
        id_valid_d = 1'b1;
        id_inst_d  = hit_data_c;
        id_pc_d    = fetch_addr_c;
      end
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      pend_q   <= 32'h0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      id_valid <= 1'b0;
      id_inst  <= 32'h0;
      id_pc    <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
      id_valid <= id_valid_d;
      id_inst  <= id_inst_d;
      id_pc    <= id_pc_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed vector table, reset-mid-transaction sequence,
// randomized run against a transaction-level model, cache sequence when
// IF_ICACHE_EN is defined.
module tb_if_fetch;
  import if_pkg::*;

  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam int unsigned LINES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ok;
  logic [31:0] mem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  int n_vec = 0;
  int n_bad = 0;

  if_fetch #(.RESET_PC(RPC), .ICACHE_LINES(LINES)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ok(mem_ok), .mem_data(mem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  // Program image: address 0 holds a NOP, everything else a hash of the address.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h0) return INST_NOP;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory byte order on the bus: byte at +0 in [31:24].
  function automatic logic [31:0] to_bus(input logic [31:0] i);
    return {i[7:0], i[15:8], i[23:16], i[31:24]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                         input logic e_vld, input logic [31:0] e_inst, input logic [31:0] e_pc);
    n_vec++;
    chk({tag, ".mem_req"},  32'(mem_req),  32'(e_req));
    chk({tag, ".mem_addr"}, mem_addr,      e_addr);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(e_vld));
    chk({tag, ".id_inst"},  id_inst,       e_inst);
    chk({tag, ".id_pc"},    id_pc,         e_pc);
  endtask

  // One clock: drive at negedge, memory answers for the current address, sample #1 after posedge.
  task automatic tick(input logic r, input logic [31:0] rp, input logic ok, input logic rd);
    @(negedge clk);
    redirect    = r;
    redirect_pc = rp;
    mem_ok      = ok;
    id_ready    = rd;
    mem_data    = ok ? to_bus(inst_of(mem_addr)) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r;
    logic [31:0] rp;
    logic        ok;
    logic        rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [31:0] rp, input logic ok, input logic rd,
                     input logic e_req, input logic [31:0] e_addr, input logic e_vld,
                     input logic [31:0] e_inst, input logic [31:0] e_pc);
    vec_t v;
    v.r = r; v.rp = rp; v.ok = ok; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld; v.e_inst = e_inst; v.e_pc = e_pc;
    tbl.push_back(v);
  endtask

  task automatic run_tbl(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].r, tbl[i].rp, tbl[i].ok, tbl[i].rd);
      chk_all($sformatf("%s[%0d]", nm, i), tbl[i].e_req, tbl[i].e_addr,
              tbl[i].e_vld, tbl[i].e_inst, tbl[i].e_pc);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 32'h0, 1'b0, 1'b0);
    chk_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
  endtask

  // ---------------- transaction-level reference model ----------------
  logic        m_first;   // one dead cycle after reset
  logic [31:0] m_pc;      // address of the current/last fetch
  logic        m_req;     // a controller request is outstanding
  logic [31:0] m_addr;    // address of that request
  logic        m_stale;   // outstanding response will be thrown away
  logic [31:0] m_target;  // where to go once the stale response arrives
  logic        m_vld;
  logic [31:0] m_inst;
  logic [31:0] m_ipc;
  logic        c_v [LINES];
  logic [31:0] c_a [LINES];

  task automatic model_reset();
    m_first = 1'b1; m_pc = RPC; m_req = 1'b0; m_addr = 32'h0;
    m_stale = 1'b0; m_target = 32'h0;
    m_vld = 1'b0; m_inst = 32'h0; m_ipc = 32'h0;
    for (int i = 0; i < LINES; i++) begin c_v[i] = 1'b0; c_a[i] = 32'h0; end
  endtask

  task automatic model_step(input logic r, input logic [31:0] rp, input logic ok, input logic rd);
    logic        start;
    logic [31:0] fa;
    logic [31:0] tgt;
    int          idx;
    tgt   = rp & 32'hFFFF_FFFC;
    start = 1'b0;
    fa    = 32'h0;
    if (m_first) begin
      m_first = 1'b0; start = 1'b1; fa = m_pc;
    end else if (m_vld) begin
      if (r)       begin start = 1'b1; fa = tgt; end
      else if (rd) begin start = 1'b1; fa = m_pc + 32'd4; end
    end else if (m_req) begin
      if (r && ok) begin
        start = 1'b1; fa = tgt;
      end else if (r) begin
        m_stale = 1'b1; m_target = tgt;
      end else if (ok) begin
        if (m_stale) begin
          start = 1'b1; fa = m_target;
        end else begin
          m_vld = 1'b1; m_inst = inst_of(m_addr); m_ipc = m_addr; m_req = 1'b0;
`ifdef IF_ICACHE_EN
          idx = int'((m_addr >> 2) % LINES);
          c_v[idx] = 1'b1; c_a[idx] = m_addr;
`endif
        end
      end
    end
    if (start) begin
      m_pc = fa; m_addr = fa; m_stale = 1'b0; m_vld = 1'b0; m_req = 1'b1;
`ifdef IF_ICACHE_EN
      idx = int'((fa >> 2) % LINES);
      if (c_v[idx] && c_a[idx] == fa) begin
        m_req = 1'b0; m_vld = 1'b1; m_inst = inst_of(fa); m_ipc = fa;
      end
`endif
    end
  endtask

  initial begin
    logic [31:0] i4, i100, i300, i3000, iffc;
    rst = 1'b1; mem_ok = 1'b0; mem_data = 32'h0; redirect = 1'b0;
    redirect_pc = 32'h0; id_ready = 1'b0;

    i4 = inst_of(32'h4); i100 = inst_of(32'h100); i300 = inst_of(32'h300);
    i3000 = inst_of(32'h3000); iffc = inst_of(32'hFFFF_FFFC);

    do_reset();

    // Directed table: r, rp, ok, rd  ->  req, addr, vld, inst, pc
    add(0, 0, 0, 0,  1, 32'h0, 0, 32'h0, 32'h0);            // IDLE -> WAIT
    add(0, 0, 0, 0,  1, 32'h0, 0, 32'h0, 32'h0);
    add(0, 0, 1, 0,  0, 32'h0, 1, INST_NOP, 32'h0);         // response -> valid next cycle
    add(0, 0, 0, 0,  0, 32'h0, 1, INST_NOP, 32'h0);         // stall 1
    add(0, 0, 1, 0,  0, 32'h0, 1, INST_NOP, 32'h0);         // stall 2, stray mem_ok ignored
    add(0, 0, 0, 0,  0, 32'h0, 1, INST_NOP, 32'h0);         // stall 3
    add(0, 0, 0, 0,  0, 32'h0, 1, INST_NOP, 32'h0);         // stall 4
    add(0, 0, 0, 0,  0, 32'h0, 1, INST_NOP, 32'h0);         // stall 5
    add(0, 0, 0, 1,  1, 32'h4, 0, INST_NOP, 32'h0);         // handshake -> fetch 4
    add(0, 0, 1, 0,  0, 32'h4, 1, i4, 32'h4);
    add(0, 0, 0, 1,  1, 32'h8, 0, i4, 32'h4);
    add(1, 32'h103, 0, 0,  1, 32'h8, 0, i4, 32'h4);         // redirect in flight -> DROP
    add(0, 0, 0, 0,  1, 32'h8, 0, i4, 32'h4);
    add(0, 0, 1, 0,  1, 32'h100, 0, i4, 32'h4);             // stale data dropped
    add(0, 0, 1, 0,  0, 32'h100, 1, i100, 32'h100);
    add(0, 0, 0, 1,  1, 32'h104, 0, i100, 32'h100);
    add(1, 32'h50, 1, 0,  1, 32'h50, 0, i100, 32'h100);     // redirect + mem_ok in WAIT
    add(1, 32'h200, 0, 0,  1, 32'h50, 0, i100, 32'h100);    // DROP
    add(1, 32'h300, 0, 0,  1, 32'h50, 0, i100, 32'h100);    // last redirect wins
    add(0, 0, 1, 0,  1, 32'h300, 0, i100, 32'h100);
    add(0, 0, 1, 0,  0, 32'h300, 1, i300, 32'h300);
    add(1, 32'h1000, 0, 1,  1, 32'h1000, 0, i300, 32'h300); // redirect beats handshake
    add(1, 32'h2000, 0, 0,  1, 32'h1000, 0, i300, 32'h300);
    add(1, 32'h3000, 1, 0,  1, 32'h3000, 0, i300, 32'h300); // redirect + mem_ok in DROP
    add(0, 0, 1, 0,  0, 32'h3000, 1, i3000, 32'h3000);
    add(1, 32'hFFFF_FFFF, 0, 0,  1, 32'hFFFF_FFFC, 0, i3000, 32'h3000);
    add(0, 0, 1, 0,  0, 32'hFFFF_FFFC, 1, iffc, 32'hFFFF_FFFC);
    add(0, 0, 0, 1,  1, 32'h0, 0, iffc, 32'hFFFF_FFFC);     // PC wraps to 0
    run_tbl("tbl");

    // Reset while a request is outstanding, then restart from RESET_PC.
    do_reset();
    tick(0, 0, 0, 0);
    chk_all("restart", 1'b1, RPC, 1'b0, 32'h0, 32'h0);

    // Randomized run against the model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        r, ok, rd;
      logic [31:0] rp;
      r  = ($urandom % 8) == 0;
      ok = m_req ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
      rd = $urandom % 2;
      case ($urandom % 4)
        0:       rp = $urandom;
        1:       rp = $urandom & 32'h7F;
        2:       rp = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        default: rp = 32'h40 + ($urandom & 32'h3F);
      endcase
      rst = (i == 1500);
      tick(r, rp, ok, rd);
      if (rst) model_reset();
      else     model_step(r, rp, ok, rd);
      chk_all($sformatf("rnd[%0d]", i), m_req, m_addr, m_vld, m_inst, m_ipc);
    end
    rst = 1'b0;

`ifdef IF_ICACHE_EN
    // Cache: revisit 0 hits; alias 0x40 evicts it.
    do_reset();
    add(0, 0, 0, 0,  1, 32'h0, 0, 32'h0, 32'h0);
    add(0, 0, 1, 0,  0, 32'h0, 1, INST_NOP, 32'h0);
    add(0, 0, 0, 1,  1, 32'h4, 0, INST_NOP, 32'h0);
    add(0, 0, 1, 0,  0, 32'h4, 1, i4, 32'h4);
    add(1, 32'h0, 0, 0,  0, 32'h0, 1, INST_NOP, 32'h0);     // hit, no request
    add(1, 32'h40, 0, 0,  1, 32'h40, 0, INST_NOP, 32'h0);   // alias miss
    add(0, 0, 1, 0,  0, 32'h40, 1, inst_of(32'h40), 32'h40);
    add(1, 32'h0, 0, 0,  1, 32'h0, 0, inst_of(32'h40), 32'h40); // evicted -> miss
    add(0, 0, 1, 0,  0, 32'h0, 1, INST_NOP, 32'h0);
    run_tbl("cache");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the byte-serial memory controller.
- Holds the PC and issues one word-fetch request at a time to the controller.
- Reorders the returned bytes into a little-endian RISC-V instruction and presents it to decode with a valid/ready handshake.
- Handles branch/jump redirects from execute, including redirects that arrive while a controller transaction is in flight.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ICACHE_LINES, 16, number of one-word lines; used only when IF_ICACHE_EN is defined; power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high. Clock is clk.
- mem_req  out  1  fetch request to the memory controller
- mem_addr  out  32  fetch byte address; always word-aligned
- mem_ok  in  1  single-cycle pulse: mem_data is valid for the current request
- mem_data  in  32  assembled word; byte at mem_addr+0 is in [31:24], +3 in [7:0]
- redirect  in  1  flush and refetch from redirect_pc
- redirect_pc  in  32  new PC; bits [1:0] are ignored (forced to 0)
- id_valid  out  1  id_inst/id_pc are valid
- id_ready  in  1  decode accepts this cycle
- id_inst  out  32  instruction, little-endian: {d[7:0],d[15:8],d[23:16],d[31:24]}
- id_pc  out  32  PC of id_inst

Behaviour:
- Reset values: pc=RESET_PC, state=IDLE, mem_req=0, mem_addr=0, id_valid=0, id_inst=0, id_pc=0.
- Reset mid-transaction abandons the transaction; the controller is reset on the same rst.

State machine (states IDLE, WAIT, DROP, OUT):
- IDLE: lasts exactly one cycle after reset. Next cycle: WAIT with mem_req=1, mem_addr=pc.
- WAIT: mem_req=1; mem_addr is held stable.
  - mem_ok → latch id_inst (byte-swapped), id_pc=pc, id_valid=1; go to OUT.
  - Latency: mem_ok in cycle N gives id_valid in cycle N+1.
- OUT: mem_req=0; id_* are held stable while id_valid && !id_ready.
  - On handshake: pc=pc+4, mem_addr=pc+4, mem_req=1, id_valid=0 next cycle; go to WAIT.
  - Throughput is at most one instruction per (controller latency + 2) cycles.
- DROP: mem_req=1; mem_addr keeps the old address.
  - Waits for mem_ok, discards mem_data, then goes to WAIT with mem_addr=pending_pc.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0.

Redirect (highest priority in every state except IDLE):
- OUT: id_valid=0 next cycle; pc=redirect_pc; go to WAIT. This holds even if id_ready is high in the same cycle — the instruction is discarded, and decode flushes on the same redirect.
- WAIT without mem_ok: pending_pc=redirect_pc; go to DROP. An in-flight transaction is never cancelled.
- WAIT with mem_ok in the same cycle: discard data; pc=redirect_pc; go to WAIT with the new address. id_valid is never raised.
- DROP: pending_pc is overwritten (last redirect wins).
- DROP with redirect and mem_ok in the same cycle: go to WAIT at the new redirect_pc.

Other rules:
- mem_ok outside WAIT/DROP is ignored.
- mem_addr[1:0] is always 0.

Optional Feature:
- Macro: IF_ICACHE_EN.
- Defined: direct-mapped instruction cache, ICACHE_LINES one-word lines.
  - index = pc[log2(ICACHE_LINES)+1:2]; tag = upper remaining PC bits; one valid bit per line.
  - Lookup happens on entry to a fetch (handshake in OUT, redirect, or leaving IDLE/DROP).
  - Hit: go directly to OUT with id_valid next cycle; mem_req stays 0.
  - Miss: normal WAIT path. The line is filled on an accepted mem_ok only; dropped responses do not fill.
  - All valid bits are cleared on rst only; there is no self-modifying-code coherence.
- Undefined: no cache storage, every fetch goes to the controller; ICACHE_LINES is unused.

Decomposition:
- Shared package if_pkg:
  - state enum (IDLE, WAIT, DROP, OUT);
  - default RESET_PC;
  - byte-swap function;
  - INST_NOP constant 32'h0000_0013 for bench use.
- One natural sub-module, if_icache: tag/valid/data arrays, plus a lookup port (addr → hit, data) and a fill port (we, addr, data). It is instantiated only under IF_ICACHE_EN.

Test Plan:
- Reset with RESET_PC=0; memory word at 0 = bytes 13 00 00 00 → mem_req with mem_addr=0; after mem_ok, id_inst=32'h0000_0013, id_pc=0, id_valid=1.
- id_ready held low 5 cycles in OUT → id_*, id_valid stable; mem_req=0. Then id_ready=1 → mem_addr=4 next cycle.
- Redirect to 32'h0000_0103 during WAIT at addr 8 → mem_addr stays 8 until mem_ok; that data is not presented; next mem_addr=32'h100; id_pc=32'h100.
- Redirect and mem_ok in the same cycle → id_valid stays 0; next mem_addr=redirect target.
- Two redirects (0x200 then 0x300) while in DROP → only 0x300 is fetched. Also: pc=32'hFFFF_FFFC, handshake → mem_addr=0.
- IF_ICACHE_EN: loop fetching 0x0,0x4,0x0 → second fetch of 0x0 produces id_valid with no mem_req. Alias 0x40 with 16 lines → miss, refill, then 0x0 misses.
